// File: rtl/nrf_pkg.sv
// Shared definitions for the nRF24L01 link blocks: wait FSM states and default timeout.
package nrf_pkg;

  localparam int unsigned NRF_DEFAULT_TIMEOUT = 100000;

  typedef enum logic [0:0] {
    WAIT_IDLE  = 1'b0,
    WAIT_ARMED = 1'b1
  } wait_state_e;

endpackage

// File: rtl/nrf_irq_sync.sv
// Two-flop synchronizer for an active-low pad input, producing an active-high level.
// Optional glitch filter compiled in with NRF_IRQ_FILTER_EN (FILTER_LEN consecutive lows).
module nrf_irq_sync #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  output logic irq
);

  logic sync_1;
  logic sync_2;

  // Flops reset to the deasserted (high) pad level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= pin_n;
      sync_2 <= sync_1;
    end
  end

`ifdef NRF_IRQ_FILTER_EN
  localparam int unsigned FW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned LEN_EFF  = (FILTER_LEN < 1) ? 1 : FILTER_LEN;
  localparam logic [FW-1:0] CNT_TOP = FW'(LEN_EFF - 1);

  // Counts prior consecutive low samples; a high sample restarts the run.
  logic [FW-1:0] low_cnt;

  always_ff @(posedge clk) begin
    if (rst || sync_2) begin
      low_cnt <= '0;
    end else if (low_cnt != CNT_TOP) begin
      low_cnt <= low_cnt + FW'(1);
    end
  end

  assign irq = ~sync_2 && (low_cnt == CNT_TOP);
`else
  logic filter_len_unused;
  assign filter_len_unused = (FILTER_LEN == 0);
  assign irq = ~sync_2;
`endif

endmodule

// File: rtl/nrf_irq_wait.sv
// Event-wait timer: waits for the nRF IRQ pin with a bounded timeout and reports the outcome.
// Input filtering is enabled by defining NRF_IRQ_FILTER_EN.
module nrf_irq_wait
  import nrf_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = NRF_DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic             i_Abort,
  input  logic             i_Irq_N,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Event,
  output logic             o_Timeout,
  output logic [CNT_W-1:0] o_Elapsed
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  wait_state_e state;
  logic        irq;

  nrf_irq_sync #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync (
    .clk  (i_Clk),
    .rst  (i_Rst),
    .pin_n(i_Irq_N),
    .irq  (irq)
  );

  // Wait FSM; abort > restart > irq > timeout > count, timeout compare before increment.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= WAIT_IDLE;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
      o_Event   <= 1'b0;
      o_Timeout <= 1'b0;
      o_Elapsed <= '0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (i_Abort) begin
            o_Event   <= 1'b0;
            o_Timeout <= 1'b0;
          end else if (i_Start) begin
            state     <= WAIT_ARMED;
            o_Busy    <= 1'b1;
            o_Elapsed <= '0;
            o_Event   <= 1'b0;
            o_Timeout <= 1'b0;
          end
        end
        WAIT_ARMED: begin
          if (i_Abort) begin
            state     <= WAIT_IDLE;
            o_Busy    <= 1'b0;
            o_Event   <= 1'b0;
            o_Timeout <= 1'b0;
          end else if (i_Start) begin
            o_Elapsed <= '0;
          end else if (irq) begin
            state   <= WAIT_IDLE;
            o_Busy  <= 1'b0;
            o_Event <= 1'b1;
            o_Done  <= 1'b1;
          end else if (o_Elapsed == LAST_CNT) begin
            state     <= WAIT_IDLE;
            o_Busy    <= 1'b0;
            o_Timeout <= 1'b1;
            o_Done    <= 1'b1;
          end else begin
            o_Elapsed <= o_Elapsed + CNT_W'(1);
          end
        end
        default: begin
          state  <= WAIT_IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/nrf_irq_wait.md
# nrf_irq_wait

Event-wait timer for the nRF24L01 link. It is the counterpart of the fixed-delay sleep timer: instead of idling a set time, it waits for the radio's active-low IRQ pin with a bounded timeout. It reports whether the IRQ or the timeout ended the wait, and how many cycles elapsed. It sits between the SPI command sequencer and the nRF IRQ pad; the sequencer arms it after a TX/RX command and resumes on `o_Done`.

## Interface
- `TIMEOUT_CYCLES`, default 100000: wait bound in `i_Clk` cycles; legal range 1 .. 2^CNT_W-1.
- `CNT_W`, default 32: width of the elapsed counter and `o_Elapsed`.
- `FILTER_LEN`, default 4: consecutive low samples required when filtering is compiled in; minimum 1.
- `i_Clk` in 1: system clock; single clock domain.
- `i_Rst` in 1: synchronous, active-high reset.
- `i_Start` in 1: single-cycle pulse; arms (or re-arms) the wait.
- `i_Abort` in 1: single-cycle pulse; cancels the wait without completion.
- `i_Irq_N` in 1: asynchronous nRF IRQ pin, active low.
- `o_Busy` out 1: high while the wait is armed.
- `o_Done` out 1: one-cycle completion pulse.
- `o_Event` out 1: sticky; the wait ended on IRQ.
- `o_Timeout` out 1: sticky; the wait ended on timeout.
- `o_Elapsed` out CNT_W: cycles counted in WAIT; holds its value after completion.

## Operation
- `i_Irq_N` passes through a 2-flop synchronizer; the synchronizer flops reset to 1 (deasserted). `irq` is the inverted synchronized value, or the filter output when filtering is enabled.
- FSM has two states, IDLE and WAIT. Reset places the FSM in IDLE and drives all outputs to 0.
- IDLE + `i_Start`: enter WAIT; clear `o_Elapsed`, `o_Event` and `o_Timeout`.
- WAIT, per cycle, in priority order:
  - `i_Abort`: go to IDLE, clear the flags, no `o_Done`.
  - `i_Start`: restart; `o_Elapsed` ← 0; stay in WAIT.
  - `irq`: go to IDLE, `o_Event` ← 1, `o_Done` pulse, `o_Elapsed` frozen.
  - `o_Elapsed == TIMEOUT_CYCLES-1`: go to IDLE, `o_Timeout` ← 1, `o_Done` pulse, `o_Elapsed` frozen.
  - Otherwise `o_Elapsed` ← `o_Elapsed`+1.
- An IRQ and the timeout in the same cycle report as an event. `o_Event` and `o_Timeout` are never both 1.
- `i_Abort` in IDLE clears the flags only. `i_Start` and `i_Abort` together in IDLE: abort wins, and the FSM stays in IDLE.
- `o_Busy` is 1 exactly when the FSM is in WAIT.
- The counter never wraps; the timeout compare precedes the increment.
- Reset mid-wait returns the block to IDLE with all outputs 0 on the next edge. No `o_Done` is issued.

## Timing
- `i_Start` is sampled at edge N; `o_Busy` is 1 from N+1.
- Pin-to-`irq` latency is 2 cycles (unfiltered). If the IRQ is already low at start, `o_Done` is high during cycle N+2 with `o_Elapsed`=0.
- Timeout: `o_Done` is high in cycle N+TIMEOUT_CYCLES+1, with `o_Elapsed`=TIMEOUT_CYCLES-1.
- `o_Done` is high for exactly one cycle. The flags and `o_Elapsed` are valid from the `o_Done` cycle until the next start, abort or reset.
- `i_Start` in the `o_Done` cycle is accepted (back-to-back waits).

## Configuration
- `NRF_IRQ_FILTER_EN` defined: `irq` asserts only after FILTER_LEN consecutive low synchronized samples. Any high sample clears the filter counter. Filtering adds FILTER_LEN-1 cycles of latency.
- `NRF_IRQ_FILTER_EN` undefined: `irq` is the synchronized sample directly, and no filter logic is built. `FILTER_LEN` is ignored.

## Structure
- Shared package `nrf_pkg`: the FSM state enum (`WAIT_IDLE`, `WAIT_ARMED`) and the default timeout constant `NRF_DEFAULT_TIMEOUT` = 100000.
- Sub-module `nrf_irq_sync`: 2-flop synchronizer plus the optional filter. Output is the level `irq`; it is reused by other pad inputs.

## Test plan
- TIMEOUT_CYCLES=10, IRQ held high, start pulse → `o_Done` 11 cycles later; `o_Timeout`=1, `o_Event`=0, `o_Elapsed`=9.
- IRQ driven low 5 cycles after start (unfiltered) → `o_Done` at start+7; `o_Event`=1, `o_Elapsed`=5.
- IRQ low before start → `o_Done` at start+2, `o_Elapsed`=0. Then a back-to-back start in the `o_Done` cycle re-arms and clears the flags.
- Abort at start+4 → `o_Busy` falls, no `o_Done`, flags 0. Reset asserted mid-wait → all outputs 0 next cycle.
- IRQ falls on the timeout cycle → `o_Event`=1, `o_Timeout`=0.
- With `NRF_IRQ_FILTER_EN`, FILTER_LEN=4: a 3-cycle IRQ glitch is ignored. A 4-cycle low completes the wait with latency 5 after the falling edge.
